imm_extend_pipe: RTL and testbench
==================================

# imm_extend_pipe

Parametrised, pipelined immediate generator for the ID stage. Decodes the immediate format from the 4-bit opcode and assembles the immediate from the three 4-bit operand nibbles. Sign- or zero-extends it to XLEN, optionally scales it by a left shift, and registers it behind a valid/ready interface with a 2-entry skid buffer. Sits between the instruction-field split and the ID/EX register and absorbs back-pressure from EX without losing or duplicating immediates.

## Interface

- XLEN, 16, output immediate width; must be ≥ 12.
- MAXSH, 3, largest legal value of `scale`; `scale` is 2 bits wide.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous and active-high.
- flush  in  1  drops all buffered entries and the entry presented on the same cycle.
- in_valid  in  1  an instruction's fields are presented.
- in_ready  out  1  the block can accept an entry.
- opcode  in  4  instruction opcode.
- one, two, three  in  4 each  operand nibbles, most significant first.
- zext  in  1  1 = zero-extend, 0 = sign-extend.
- scale  in  2  left shift applied after extension; values above MAXSH saturate to MAXSH.
- out_valid  out  1  `out_imm` and `out_kind` are valid.
- out_ready  in  1  the consumer takes the output this cycle.
- out_imm  out  XLEN  extended, scaled immediate.
- out_kind  out  2  immediate format: 00 = A, 01 = B, 10 = C, 11 = D.

## Operation

Format decode is combinational on the input side:
- B (opcode 1000, 1011): raw = `three`, 4 bits, kind 01.
- C (opcode 0100, 0101, 0110): raw = {two, three}, 8 bits, kind 10.
- D (opcode 1100, 1111): raw = {one, two, three}, 12 bits, kind 11.
- A (all other opcodes): raw = `two`, 4 bits, kind 00.

Extension and scaling:
- Sign-extend: every bit above the raw width equals the raw MSB. A raw value of 4'hA with XLEN = 16 gives 16'hFFFA.
- Zero-extend: every bit above the raw width is 0.
- The extended value is shifted left by min(scale, MAXSH). Bits shifted past XLEN-1 are discarded. Vacated LSBs are 0.

Storage is an output register (`out_*`) plus one skid register.
- in_ready = NOT skid_valid. It depends on state only and has no combinational path from out_ready.
- accept = in_valid AND in_ready.
- drain = out_valid AND out_ready.
- The extended, scaled value and its kind are captured on the accept cycle; the inputs are not needed after that.

Next-state rules, in priority order:
- rst: out_valid = 0, skid_valid = 0, out_imm = 0, out_kind = 00. in_ready reads 1 after reset.
- flush: out_valid = 0, skid_valid = 0. An entry accepted in the same cycle is discarded. Data registers hold their values.
- drain and skid_valid: out takes the skid contents, skid_valid = 0.
- drain, no skid, accept: out takes the new entry.
- drain, no skid, no accept: out_valid = 0.
- not out_valid and accept: out takes the new entry.
- out_valid, no drain, accept: skid takes the new entry, skid_valid = 1.
- Otherwise hold.

Invariants:
- Entries leave in acceptance order.
- skid_valid = 1 implies out_valid = 1.
- While out_valid = 1 and out_ready = 0, out_imm and out_kind hold stable.

## Timing

- Latency is 1 cycle: an entry accepted at edge N drives out_valid = 1 after edge N, provided the output register was empty or draining.
- Sustained throughput is 1 entry per cycle when out_ready stays high.
- After out_ready is held low, at most 2 entries are absorbed. in_ready drops in the cycle after the second accept.
- in_ready returns to 1 in the cycle after the first drain that empties the skid register.
- Flush or reset asserted in cycle N: out_valid = 0 and in_ready = 1 from cycle N+1.
- Reset mid-stream has the same effect as flush and additionally zeroes out_imm and out_kind.

## Test plan

- Formats, XLEN = 16, scale = 0, zext = 0, out_ready = 1:
  - opcode 1000, three = A -> FFFA, kind 01.
  - opcode 0101, two = 8, three = 1 -> FF81, kind 10.
  - opcode 1111, one = 7, two = F, three = F -> 07FF, kind 11.
  - opcode 0000, two = 3 -> 0003, kind 00.
- Extend and scale:
  - Repeat the C case with zext = 1 -> 0081.
  - D case with scale = 1 -> 0FFE.
  - B case three = 8 with scale = 3 -> FFC0.
- Back-pressure: out_ready = 0, send immediates 1, 2, 3 on back-to-back cycles.
  - in_ready goes low after the second accept; 3 is not accepted.
  - Raise out_ready: outputs appear as 1, 2, then 3 once it is re-presented. No loss or duplication.
- Full-rate stream: 20 random entries with random out_ready toggling.
  - The output sequence equals a reference-model queue.
  - out_imm stays stable whenever out_valid = 1 and out_ready = 0.
- Flush with both registers full and in_valid = 1 on the same cycle:
  - Next cycle out_valid = 0 and in_ready = 1.
  - None of the three entries ever appears on the output.
- Reset asserted mid-stream together with flush:
  - Next cycle out_valid = 0, out_imm = 0000, out_kind = 00, in_ready = 1.
  - The first entry after reset emerges with 1-cycle latency.

Source files
------------

// File: rtl/imm_extend_pipe_if.sv
// imm_extend_pipe_if
//   Groups the producer-side (instruction fields, flush, in_valid/in_ready)
//   and consumer-side (out_valid/out_ready, out_imm, out_kind) signals of
//   the immediate generator.
//   Modports:
//     slave  - the immediate generator itself
//     master - the environment driving fields and consuming immediates
//   Parameter XLEN must match the XLEN of the attached imm_extend_pipe.
interface imm_extend_pipe_if #(
    parameter int XLEN = 16
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      opcode;
    logic [3:0]      one;
    logic [3:0]      two;
    logic [3:0]      three;
    logic            zext;
    logic [1:0]      scale;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [1:0]      out_kind;

    modport slave (
        input  flush, in_valid, opcode, one, two, three, zext, scale, out_ready,
        output in_ready, out_valid, out_imm, out_kind
    );

    modport master (
        output flush, in_valid, opcode, one, two, three, zext, scale, out_ready,
        input  in_ready, out_valid, out_imm, out_kind
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
//   ID-stage immediate generator. Decodes the immediate format from the
//   opcode, assembles the raw immediate from the operand nibbles, sign- or
//   zero-extends it to XLEN, shifts it left by a saturated scale and hands
//   it to EX through an output register backed by one skid register.
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset
//     bus  - imm_extend_pipe_if.slave (fields, flush, valid/ready, result)
//   Parameters:
//     XLEN  - output width, at least 12
//     MAXSH - largest honoured shift; larger scale values saturate to it
module imm_extend_pipe #(
    parameter int XLEN  = 16,
    parameter int MAXSH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    imm_extend_pipe_if.slave     bus
);

    localparam logic [1:0] MAXSH_C = 2'(MAXSH);

    localparam logic [1:0] KIND_A = 2'b00;
    localparam logic [1:0] KIND_B = 2'b01;
    localparam logic [1:0] KIND_C = 2'b10;
    localparam logic [1:0] KIND_D = 2'b11;

    // Input-side decode results
    logic [1:0]      kind_s;
    logic [11:0]     raw12_s;   // raw immediate already extended to 12 bits
    logic            sgn_s;     // fill bit for everything above bit 11
    logic [XLEN-1:0] ext_s;
    logic [1:0]      scale_s;
    logic [XLEN-1:0] imm_s;

    // Handshake
    logic accept_s;
    logic drain_s;

    // Storage
    logic            out_valid_r;
    logic [XLEN-1:0] out_imm_r;
    logic [1:0]      out_kind_r;
    logic            skid_valid_r;
    logic [XLEN-1:0] skid_imm_r;
    logic [1:0]      skid_kind_r;

    // Format decode and extension of the raw immediate to 12 bits
    always_comb begin
        kind_s  = KIND_A;
        raw12_s = 12'h000;
        sgn_s   = 1'b0;
        case (bus.opcode)
            4'b1000, 4'b1011: begin
                kind_s  = KIND_B;
                sgn_s   = ~bus.zext & bus.three[3];
                raw12_s = {{8{sgn_s}}, bus.three};
            end
            4'b0100, 4'b0101, 4'b0110: begin
                kind_s  = KIND_C;
                sgn_s   = ~bus.zext & bus.two[3];
                raw12_s = {{4{sgn_s}}, bus.two, bus.three};
            end
            4'b1100, 4'b1111: begin
                kind_s  = KIND_D;
                sgn_s   = ~bus.zext & bus.one[3];
                raw12_s = {bus.one, bus.two, bus.three};
            end
            default: begin
                kind_s  = KIND_A;
                sgn_s   = ~bus.zext & bus.two[3];
                raw12_s = {{8{sgn_s}}, bus.two};
            end
        endcase
    end

    // Widen to XLEN (fill above bit 11 with the sign) and apply saturated scale
    always_comb begin
        ext_s        = {XLEN{sgn_s}};
        ext_s[11:0]  = raw12_s;
        if (bus.scale > MAXSH_C) begin
            scale_s = MAXSH_C;
        end else begin
            scale_s = bus.scale;
        end
        imm_s = ext_s << scale_s;
    end

    // in_ready depends only on state, so there is no path from out_ready
    assign bus.in_ready  = ~skid_valid_r;
    assign accept_s      = bus.in_valid & ~skid_valid_r;
    assign drain_s       = out_valid_r & bus.out_ready;

    assign bus.out_valid = out_valid_r;
    assign bus.out_imm   = out_imm_r;
    assign bus.out_kind  = out_kind_r;

    // Output register and skid register update, in priority order
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_imm_r    <= {XLEN{1'b0}};
            out_kind_r   <= 2'b00;
            skid_valid_r <= 1'b0;
            skid_imm_r   <= {XLEN{1'b0}};
            skid_kind_r  <= 2'b00;
        end else if (bus.flush) begin
            // data registers keep their contents; only the valids drop
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (drain_s && skid_valid_r) begin
            // accept cannot coincide here: in_ready is low while skid is full
            out_imm_r    <= skid_imm_r;
            out_kind_r   <= skid_kind_r;
            skid_valid_r <= 1'b0;
        end else if (drain_s && accept_s) begin
            out_imm_r    <= imm_s;
            out_kind_r   <= kind_s;
        end else if (drain_s) begin
            out_valid_r  <= 1'b0;
        end else if (!out_valid_r && accept_s) begin
            out_valid_r  <= 1'b1;
            out_imm_r    <= imm_s;
            out_kind_r   <= kind_s;
        end else if (out_valid_r && accept_s) begin
            skid_valid_r <= 1'b1;
            skid_imm_r   <= imm_s;
            skid_kind_r  <= kind_s;
        end else begin
            out_valid_r  <= out_valid_r;
            skid_valid_r <= skid_valid_r;
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe
//   Directed, table-driven bench for imm_extend_pipe (XLEN = 16, MAXSH = 3)
//   plus hand-written back-pressure, random-stream, flush and reset sequences.
module tb_imm_extend_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;

    imm_extend_pipe_if #(.XLEN(16)) bus ();

    imm_extend_pipe #(.XLEN(16), .MAXSH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0]  opcode;
        logic [3:0]  one;
        logic [3:0]  two;
        logic [3:0]  three;
        logic        zext;
        logic [1:0]  scale;
        logic [15:0] imm;
        logic [1:0]  kind;
    } vec_t;

    vec_t vecs [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_fields(input logic [3:0] op, input logic [3:0] o, input logic [3:0] t,
                              input logic [3:0] th, input logic z, input logic [1:0] s);
        bus.opcode = op;
        bus.one    = o;
        bus.two    = t;
        bus.three  = th;
        bus.zext   = z;
        bus.scale  = s;
    endtask

    // Arithmetic reference: {kind, imm}
    function automatic logic [17:0] model(input logic [3:0] op, input logic [3:0] o,
                                          input logic [3:0] t, input logic [3:0] th,
                                          input logic z, input logic [1:0] s);
        int w;
        int v;
        logic [1:0] k;
        case (op)
            4'b1000, 4'b1011:          begin w = 4;  v = int'(th);                          k = 2'b01; end
            4'b0100, 4'b0101, 4'b0110: begin w = 8;  v = int'(t) * 16 + int'(th);          k = 2'b10; end
            4'b1100, 4'b1111:          begin w = 12; v = int'(o) * 256 + int'(t) * 16 + int'(th); k = 2'b11; end
            default:                   begin w = 4;  v = int'(t);                           k = 2'b00; end
        endcase
        if (!z && v >= (1 << (w - 1))) v = v - (1 << w);
        v = v * (1 << s);
        return {k, v[15:0]};
    endfunction

    logic [17:0]  q [$];
    logic [17:0]  exp_e;
    logic         acc, drn, hold;
    logic [15:0]  hold_imm;
    logic [1:0]   hold_kind;
    int           sent, got;

    initial begin
        vecs[0]  = '{4'b1000, 4'h5, 4'h6, 4'hA, 1'b0, 2'd0, 16'hFFFA, 2'b01};
        vecs[1]  = '{4'b0101, 4'h2, 4'h8, 4'h1, 1'b0, 2'd0, 16'hFF81, 2'b10};
        vecs[2]  = '{4'b1111, 4'h7, 4'hF, 4'hF, 1'b0, 2'd0, 16'h07FF, 2'b11};
        vecs[3]  = '{4'b0000, 4'h9, 4'h3, 4'hC, 1'b0, 2'd0, 16'h0003, 2'b00};
        vecs[4]  = '{4'b0101, 4'h2, 4'h8, 4'h1, 1'b1, 2'd0, 16'h0081, 2'b10};
        vecs[5]  = '{4'b1111, 4'h7, 4'hF, 4'hF, 1'b0, 2'd1, 16'h0FFE, 2'b11};
        vecs[6]  = '{4'b1000, 4'h0, 4'h0, 4'h8, 1'b0, 2'd3, 16'hFFC0, 2'b01};
        vecs[7]  = '{4'b1011, 4'h1, 4'h2, 4'h7, 1'b0, 2'd0, 16'h0007, 2'b01};
        vecs[8]  = '{4'b0110, 4'h0, 4'hF, 4'hF, 1'b0, 2'd2, 16'hFFFC, 2'b10};
        vecs[9]  = '{4'b1100, 4'h8, 4'h0, 4'h0, 1'b0, 2'd0, 16'hF800, 2'b11};
        vecs[10] = '{4'b1100, 4'h8, 4'h0, 4'h0, 1'b1, 2'd3, 16'h4000, 2'b11};
        vecs[11] = '{4'b0011, 4'h1, 4'hF, 4'h2, 1'b1, 2'd0, 16'h000F, 2'b00};
        vecs[12] = '{4'b1001, 4'h4, 4'h8, 4'h3, 1'b0, 2'd0, 16'hFFF8, 2'b00};
        vecs[13] = '{4'b0100, 4'h0, 4'h7, 4'hF, 1'b0, 2'd3, 16'h03F8, 2'b10};
        vecs[14] = '{4'b1000, 4'h0, 4'h0, 4'hF, 1'b1, 2'd2, 16'h003C, 2'b01};
        vecs[15] = '{4'b0111, 4'h0, 4'hA, 4'h0, 1'b0, 2'd1, 16'hFFF4, 2'b00};

        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        set_fields(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0);

        // ---------------- reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_imm",   32'(bus.out_imm),   32'h0000);
        chk("rst_out_kind",  32'(bus.out_kind),  32'd0);

        // ---------------- table-driven formats / extension / scale
        for (int i = 0; i < 16; i++) begin
            set_fields(vecs[i].opcode, vecs[i].one, vecs[i].two, vecs[i].three,
                       vecs[i].zext, vecs[i].scale);
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("vec%0d_imm", i),   32'(bus.out_imm),   32'(vecs[i].imm));
            chk($sformatf("vec%0d_kind", i),  32'(bus.out_kind),  32'(vecs[i].kind));
        end
        tick();
        chk("table_drained", 32'(bus.out_valid), 32'd0);

        // ---------------- back-pressure: 1, 2, 3 with out_ready low
        bus.out_ready = 1'b0;
        set_fields(4'b0000, 4'h0, 4'h1, 4'h0, 1'b0, 2'd0);
        bus.in_valid = 1'b1;
        tick();
        chk("bp1_imm",      32'(bus.out_imm),  32'h0001);
        chk("bp1_in_ready", 32'(bus.in_ready), 32'd1);
        set_fields(4'b0000, 4'h0, 4'h2, 4'h0, 1'b0, 2'd0);
        tick();
        chk("bp2_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp2_imm_hold", 32'(bus.out_imm),  32'h0001);
        set_fields(4'b0000, 4'h0, 4'h3, 4'h0, 1'b0, 2'd0);
        tick();
        chk("bp3_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp3_imm_hold", 32'(bus.out_imm),  32'h0001);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_out2",      32'(bus.out_imm),  32'h0002);
        chk("bp_out2_rdy",  32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_out3",       32'(bus.out_imm),   32'h0003);
        chk("bp_out3_valid", 32'(bus.out_valid), 32'd1);
        tick();
        chk("bp_empty", 32'(bus.out_valid), 32'd0);

        // ---------------- random stream against a reference queue
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 600 && got < 20; cyc++) begin
            if (!bus.in_valid && sent < 20) begin
                set_fields(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
                bus.in_valid = 1'b1;
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            acc = bus.in_valid & bus.in_ready;
            drn = bus.out_valid & bus.out_ready;
            if (drn) begin
                if (q.size() == 0) begin
                    chk("stream_spurious", 32'd1, 32'd0);
                end else begin
                    exp_e = q.pop_front();
                    chk("stream_imm",  32'(bus.out_imm),  32'(exp_e[15:0]));
                    chk("stream_kind", 32'(bus.out_kind), 32'(exp_e[17:16]));
                end
                got++;
            end
            hold      = bus.out_valid & ~bus.out_ready;
            hold_imm  = bus.out_imm;
            hold_kind = bus.out_kind;
            if (acc) begin
                q.push_back(model(bus.opcode, bus.one, bus.two, bus.three, bus.zext, bus.scale));
            end
            tick();
            if (hold) begin
                chk("stream_hold_valid", 32'(bus.out_valid), 32'd1);
                chk("stream_hold_imm",   32'(bus.out_imm),   32'(hold_imm));
                chk("stream_hold_kind",  32'(bus.out_kind),  32'(hold_kind));
            end
            if (acc) begin
                sent++;
                bus.in_valid = 1'b0;
            end
        end
        chk("stream_count", 32'(got), 32'd20);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        q.delete();

        // ---------------- flush with out + skid full and in_valid high
        bus.out_ready = 1'b0;
        set_fields(4'b0000, 4'h0, 4'h4, 4'h0, 1'b0, 2'd0);
        bus.in_valid = 1'b1;
        tick();
        set_fields(4'b0000, 4'h0, 4'h5, 4'h0, 1'b0, 2'd0);
        tick();
        chk("fl_full", 32'(bus.in_ready), 32'd0);
        set_fields(4'b0000, 4'h0, 4'h6, 4'h0, 1'b0, 2'd0);
        bus.flush = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_out_valid", 32'(bus.out_valid), 32'd0);
        chk("fl_in_ready",  32'(bus.in_ready),  32'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_none_out", 32'(bus.out_valid), 32'd0);
        end

        // flush discards an entry accepted on the same cycle into an empty pipe
        set_fields(4'b0000, 4'h0, 4'h7, 4'h0, 1'b0, 2'd0);
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_same_cycle", 32'(bus.out_valid), 32'd0);

        // ---------------- reset mid-stream together with flush
        bus.out_ready = 1'b0;
        set_fields(4'b1111, 4'h3, 4'hC, 4'h9, 1'b0, 2'd1);
        bus.in_valid = 1'b1;
        tick();
        tick();
        chk("rs_before", 32'(bus.out_valid), 32'd1);
        rst       = 1'b1;
        bus.flush = 1'b1;
        tick();
        rst       = 1'b0;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("rs_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rs_out_imm",   32'(bus.out_imm),   32'h0000);
        chk("rs_out_kind",  32'(bus.out_kind),  32'd0);
        chk("rs_in_ready",  32'(bus.in_ready),  32'd1);
        bus.out_ready = 1'b1;
        set_fields(4'b1100, 4'h1, 4'h2, 4'h3, 1'b0, 2'd0);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("rs_first_valid", 32'(bus.out_valid), 32'd1);
        chk("rs_first_imm",   32'(bus.out_imm),   32'h0123);
        chk("rs_first_kind",  32'(bus.out_kind),  32'd3);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
